// File: rtl/key_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// default board timing and the millisecond-to-clock-cycle conversion.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int DEF_CLK_HZ        = 50_000_000;
  localparam int DEF_DEBOUNCE_MS   = 20;
  localparam int DEF_LONG_PRESS_MS = 1000;

  // Divide first so 50 MHz * 1000 ms still fits in a 32-bit int.
  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; the reset value lets
// each input start at its idle level so no false edge follows reset.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// Push-button front end: synchronise, debounce, and emit press/release/long-press
// pulses plus a press-toggled flag.
//
//   state        | meaning
//   IDLE         | stable released
//   PRESS_WAIT   | press seen, waiting DEB_CYC stable cycles
//   PRESSED      | stable pressed
//   RELEASE_WAIT | release seen, waiting DEB_CYC stable cycles
module key_debouncer
  import key_pkg::*;
#(
  parameter int CLK_HZ        = DEF_CLK_HZ,
  parameter int DEBOUNCE_MS   = DEF_DEBOUNCE_MS,
  parameter int LONG_PRESS_MS = DEF_LONG_PRESS_MS,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic KEY_IN,
  output logic KEY_LEVEL,
  output logic PRESS_PULSE,
  output logic RELEASE_PULSE,
  output logic LONG_PULSE,
  output logic TOGGLE
);

  localparam int DEB_CYC  = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cyc(CLK_HZ, LONG_PRESS_MS);
  localparam int DEB_W    = $clog2(DEB_CYC + 1);
  localparam int LONG_W   = $clog2(LONG_CYC + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYC);

  logic              key_sync;
  logic              key_s;
  key_state_t        state, state_nxt;
  logic [DEB_W-1:0]  deb_cnt, deb_cnt_nxt;
  logic [LONG_W-1:0] hold_cnt;
  logic              press_evt;
  logic              release_evt;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (ACTIVE_LOW ? 1'b1 : 1'b0)
  ) u_sync (
    .clk_sys (CLOCK_50),
    .rst_b   (RESET_N),
    .d       (KEY_IN),
    .q       (key_sync)
  );

  assign key_s = ACTIVE_LOW ? ~key_sync : key_sync;

  // The cycle that detects the change only opens the window; DEB_CYC further
  // stable samples are then required inside the WAIT state.
  always_comb begin
    state_nxt   = state;
    deb_cnt_nxt = deb_cnt;
    case (state)
      IDLE: begin
        if (key_s) begin
          state_nxt   = PRESS_WAIT;
          deb_cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_nxt   = IDLE;
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = PRESSED;
          deb_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + DEB_W'(1);
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_nxt   = RELEASE_WAIT;
          deb_cnt_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_nxt   = PRESSED;
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = IDLE;
          deb_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + DEB_W'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        deb_cnt_nxt = '0;
      end
    endcase
  end

  assign press_evt   = (state == PRESS_WAIT)   && (state_nxt == PRESSED);
  assign release_evt = (state == RELEASE_WAIT) && (state_nxt == IDLE);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      KEY_LEVEL     <= 1'b0;
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      LONG_PULSE    <= 1'b0;
      TOGGLE        <= 1'b0;
    end else begin
      state         <= state_nxt;
      deb_cnt       <= deb_cnt_nxt;
      KEY_LEVEL     <= (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
      PRESS_PULSE   <= press_evt;
      RELEASE_PULSE <= release_evt;
      if (press_evt) begin
        TOGGLE <= ~TOGGLE;
      end
      // Hold count keeps running through release bounces; saturation stops repeats.
      if (press_evt) begin
        hold_cnt <= '0;
      end else if (KEY_LEVEL && (hold_cnt != LONG_MAX)) begin
        hold_cnt <= hold_cnt + LONG_W'(1);
      end
      LONG_PULSE <= !press_evt && KEY_LEVEL && (hold_cnt == LONG_MAX - LONG_W'(1));
    end
  end

endmodule
